// File: rtl/sender_pkg.sv
// Shared definitions for the PGNoC switch output stage.
//  - state_e   : sender FSM states
//  - PORT_*    : mesh port indices (local port index is PORTS_NUM)
//  - ADDR_LSB  : destination address offset within a flit (tail bit sits at ADDR_SIZE)
//  - flit_bus_size() : flit width from payload and address widths
package sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } state_e;

  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_S = 2;
  localparam int unsigned PORT_W = 3;

  localparam int unsigned ADDR_LSB = 0;

  // Flit = data | tail | dest addr
  function automatic int unsigned flit_bus_size(input int unsigned data_size,
                                                input int unsigned addr_size);
    return data_size + addr_size + 1;
  endfunction

endpackage

// File: rtl/sender_if.sv
// Bus bundle between the switch FIFO / downstream receivers and the sender.
//  is_empty     FIFO empty
//  data_i       FIFO read data (valid the cycle after rd_req)
//  rd_req       FIFO pop pulse
//  r_ready_in   per-port accept pulse from downstream receivers
//  wr_ready_out per-port flit-valid
//  data_o       per-port flit slices
//  stall_err    sticky watchdog flag
// master = sender side, slave = FIFO/receiver side.
interface sender_if
  import sender_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned PORTS_NUM = 4
);
  localparam int unsigned BUS_SIZE = flit_bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int unsigned NPORTS   = PORTS_NUM + 1;

  logic                       is_empty;
  logic [BUS_SIZE-1:0]        data_i;
  logic                       rd_req;
  logic [NPORTS-1:0]          r_ready_in;
  logic [NPORTS-1:0]          wr_ready_out;
  logic [NPORTS*BUS_SIZE-1:0] data_o;
  logic                       stall_err;

  modport master (
    input  is_empty, data_i, r_ready_in,
    output rd_req, wr_ready_out, data_o, stall_err
  );

  modport slave (
    output is_empty, data_i, r_ready_in,
    input  rd_req, wr_ready_out, data_o, stall_err
  );

endinterface

// File: rtl/sender_xy_route.sv
// Combinational XY router: resolves X first, then Y, else local.
//  addr   in  ADDR_SIZE  destination, [ADDR_SIZE-1:ADDR_SIZE/2]=Y, [ADDR_SIZE/2-1:0]=X
//  port_c out PW         output port index (0=N 1=E 2=S 3=W, PORTS_NUM=local)
module sender_xy_route
  import sender_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned PORTS_NUM = 4,
  parameter int unsigned NODE_X    = 0,
  parameter int unsigned NODE_Y    = 0,
  parameter int unsigned PW        = $clog2(PORTS_NUM + 1)
) (
  input  logic [ADDR_SIZE-1:0] addr,
  output logic [PW-1:0]        port_c
);
  localparam int unsigned HW = ADDR_SIZE / 2;
  localparam logic [HW-1:0] NX = HW'(NODE_X);
  localparam logic [HW-1:0] NY = HW'(NODE_Y);

  logic [HW-1:0] dx;
  logic [HW-1:0] dy;

  assign dx = addr[0 +: HW];
  assign dy = addr[HW +: HW];

  always_comb begin
    port_c = PW'(PORTS_NUM);
    if (dx > NX)      port_c = PW'(PORT_E);
    else if (dx < NX) port_c = PW'(PORT_W);
    else if (dy > NY) port_c = PW'(PORT_S);
    else if (dy < NY) port_c = PW'(PORT_N);
  end

endmodule

// File: rtl/sender.sv
// PGNoC switch output stage: pops flits from the switch FIFO, XY-routes each
// packet on its head flit and holds the chosen port until the tail is accepted.
//  clk    in  clock, rising edge
//  a_rst  in  asynchronous active-high reset
//  bus    sender_if.master (FIFO read side + per-port flit handshake)
// Optional: define SENDER_WATCHDOG_EN to add the SEND-stall watchdog
// (WD_CYCLES parameter, sticky stall_err); otherwise stall_err is tied 0.
module sender
  import sender_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned PORTS_NUM = 4,
  parameter int unsigned NODE_X    = 0,
  parameter int unsigned NODE_Y    = 0
`ifdef SENDER_WATCHDOG_EN
  ,
  parameter int unsigned WD_CYCLES = 255
`endif
) (
  input logic      clk,
  input logic      a_rst,
  sender_if.master bus
);
  localparam int unsigned BUS_SIZE = flit_bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int unsigned NPORTS   = PORTS_NUM + 1;
  localparam int unsigned PW       = $clog2(NPORTS);
  localparam int unsigned TAIL_BIT = ADDR_SIZE;

  state_e                     state_q, state_d;
  logic [PW-1:0]              port_q, port_d, route_c;
  logic [BUS_SIZE-1:0]        flit_q, flit_d;
  logic                       head_q, head_d;
  logic                       rd_req_c;
  logic                       accept_c;
  logic [NPORTS-1:0]          wr_d, wr_q;
  logic [NPORTS*BUS_SIZE-1:0] data_d, data_q;

  sender_xy_route #(
    .ADDR_SIZE(ADDR_SIZE),
    .PORTS_NUM(PORTS_NUM),
    .NODE_X   (NODE_X),
    .NODE_Y   (NODE_Y),
    .PW       (PW)
  ) u_route (
    .addr  (bus.data_i[ADDR_LSB +: ADDR_SIZE]),
    .port_c(route_c)
  );

  // Only the locked port's accept counts
  assign accept_c = bus.r_ready_in[port_q];

  // State register
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      port_q  <= PW'(PORTS_NUM);
      flit_q  <= '0;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      flit_q  <= flit_d;
      head_q  <= head_d;
    end
  end

  // Next state; head_q remembers whether the pending load opens a packet
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    flit_d   = flit_q;
    head_d   = head_q;
    rd_req_c = 1'b0;
    case (state_q)
      IDLE: if (!bus.is_empty) begin
        rd_req_c = 1'b1;
        head_d   = 1'b1;
        state_d  = LOAD;
      end
      FETCH: if (!bus.is_empty) begin
        rd_req_c = 1'b1;
        head_d   = 1'b0;
        state_d  = LOAD;
      end
      LOAD: begin
        flit_d = bus.data_i;
        if (head_q) port_d = route_c;
        state_d = SEND;
      end
      SEND: if (accept_c) state_d = flit_q[TAIL_BIT] ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Port outputs are registered from next-state values
  always_comb begin
    wr_d   = '0;
    data_d = '0;
    if (state_d == SEND) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (port_d == PW'(p)) begin
          wr_d[p]                       = 1'b1;
          data_d[p*BUS_SIZE +: BUS_SIZE] = flit_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      data_q <= data_d;
    end
  end

  // FIFO pop must land data in LOAD, so it is decoded directly; masked in reset
  assign bus.rd_req       = rd_req_c & ~a_rst;
  assign bus.wr_ready_out = wr_q;
  assign bus.data_o       = data_q;

`ifdef SENDER_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       stall_q;

  // Counts SEND cycles without accept; cleared outside SEND, saturates
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q != SEND)                   wd_cnt_d = '0;
    else if (!accept_c && wd_cnt_q != '1)  wd_cnt_d = wd_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wd_cnt_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (state_q == SEND && wd_cnt_d == 8'(WD_CYCLES)) stall_q <= 1'b1;
    end
  end

  assign bus.stall_err = stall_q;
`else
  assign bus.stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_sender.sv
module tb_sender;
  localparam int unsigned DS  = 32;
  localparam int unsigned AS  = 4;
  localparam int unsigned PN  = 4;
  localparam int unsigned BUS = DS + AS + 1;
  localparam int unsigned NP  = PN + 1;
`ifdef SENDER_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk;
  logic a_rst;

  sender_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN)) bif ();

  sender #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN), .NODE_X(1), .NODE_Y(1)
`ifdef SENDER_WATCHDOG_EN
    , .WD_CYCLES(8)
`endif
  ) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int rdreq_cnt = 0;
  bit force_empty = 1'b0;
  logic [BUS-1:0] fifo[$];
  logic [BUS-1:0] exp_flit[$];
  int             exp_port[$];

  // Reference routing rule: X first, then Y, else local (node at 1,1)
  function automatic int xy_port(input logic [3:0] a);
    int x, y;
    x = int'(a[1:0]);
    y = int'(a[3:2]);
    if (x > 1) return 1;
    if (x < 1) return 3;
    if (y > 1) return 2;
    if (y < 1) return 0;
    return 4;
  endfunction

  function automatic logic [BUS-1:0] mk_flit(input logic [3:0] addr, input bit tail);
    logic [DS-1:0] d;
    d = DS'($urandom);
    return {d, tail, addr};
  endfunction

  function automatic logic [NP*BUS-1:0] place(input logic [BUS-1:0] f, input int p);
    logic [NP*BUS-1:0] v;
    v = '0;
    v[p*BUS +: BUS] = f;
    return v;
  endfunction

  task automatic upd_empty();
    bif.is_empty = (fifo.size() == 0) || force_empty;
  endtask

  // Push a packet into the FIFO and, if scored, the expected stream
  task automatic push_pkt(input logic [3:0] head_addr, input int len, input bit scored);
    logic [BUS-1:0] f;
    int p;
    p = xy_port(head_addr);
    for (int i = 0; i < len; i++) begin
      f = mk_flit((i == 0) ? head_addr : 4'($urandom), (i == len - 1));
      fifo.push_back(f);
      if (scored) begin
        exp_flit.push_back(f);
        exp_port.push_back(p);
      end
    end
    upd_empty();
  endtask

  // One clock: entered and left at negedge; models the FIFO read port
  task automatic tick();
    bit rr;
    #1;
    rr = bif.rd_req;
    if (rr) begin
      rdreq_cnt++;
      checks++;
      if (bif.is_empty !== 1'b0 || bif.wr_ready_out !== '0)
        $display("FAIL rd_req_guard: rd_req with is_empty=%b wr_ready_out=%b", bif.is_empty, bif.wr_ready_out);
      else passed++;
    end
    @(posedge clk);
    #1;
    if (rr && fifo.size() > 0) bif.data_i = fifo.pop_front();
    upd_empty();
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    bif.r_ready_in = '0;
    bif.data_i = '0;
    fifo.delete();
    exp_flit.delete();
    exp_port.delete();
    force_empty = 1'b0;
    upd_empty();
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboarded traffic with random accept delay, noise on other ports, FIFO gaps
  task automatic run_traffic(input int budget, input int max_delay, input bit gaps);
    int wait_cnt;
    bit prev_acc;
    logic [NP-1:0] exp_w, noise;
    wait_cnt = $urandom_range(0, max_delay);
    prev_acc = 1'b0;
    while (exp_flit.size() > 0 && budget > 0) begin
      budget--;
      force_empty = gaps && ($urandom_range(0, 3) == 0);
      upd_empty();
      if (prev_acc) begin
        checks++;
        if (bif.wr_ready_out !== '0) $display("FAIL drop_after_accept: wr_ready_out=%b required 0", bif.wr_ready_out);
        else passed++;
        prev_acc = 1'b0;
      end
      bif.r_ready_in = '0;
      if (bif.wr_ready_out !== '0) begin
        exp_w = NP'(1) << exp_port[0];
        noise = NP'($urandom);
        checks++;
        if (bif.wr_ready_out !== exp_w) $display("FAIL traffic_port: wr_ready_out=%b required %b", bif.wr_ready_out, exp_w);
        else passed++;
        checks++;
        if (bif.data_o !== place(exp_flit[0], exp_port[0]))
          $display("FAIL traffic_data: data_o=%h required %h", bif.data_o, place(exp_flit[0], exp_port[0]));
        else passed++;
        if (wait_cnt == 0) begin
          bif.r_ready_in = noise | exp_w;
          void'(exp_flit.pop_front());
          void'(exp_port.pop_front());
          prev_acc = 1'b1;
          wait_cnt = $urandom_range(0, max_delay);
        end else begin
          bif.r_ready_in = noise & ~exp_w;
          wait_cnt--;
        end
      end
      tick();
    end
    bif.r_ready_in = '0;
    force_empty = 1'b0;
    upd_empty();
    checks++;
    if (exp_flit.size() != 0) $display("FAIL traffic_timeout: %0d flits outstanding, required 0", exp_flit.size());
    else passed++;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    bif.is_empty = 1'b0;
    bif.data_i = '0;
    bif.r_ready_in = '1;
    #1;
    checks++;
    if ({bif.rd_req, bif.wr_ready_out, bif.stall_err} !== '0 || bif.data_o !== '0)
      $display("FAIL reset_outputs: rd_req=%b wr=%b stall=%b data_o=%h required all 0",
               bif.rd_req, bif.wr_ready_out, bif.stall_err, bif.data_o);
    else passed++;
    do_reset();
    repeat (3) begin
      #1;
      checks++;
      if (bif.rd_req !== 1'b0 || bif.wr_ready_out !== '0)
        $display("FAIL reset_idle: rd_req=%b wr=%b required 0", bif.rd_req, bif.wr_ready_out);
      else passed++;
      tick();
    end
  endtask

  task automatic test_route_e();
    logic [BUS-1:0] f;
    do_reset();
    f = mk_flit(4'b0110, 1'b1);
    fifo.push_back(f);
    upd_empty();
    rdreq_cnt = 0;
    tick();
    checks++;
    if (bif.wr_ready_out !== '0) $display("FAIL route_e_latency1: wr=%b required 0", bif.wr_ready_out);
    else passed++;
    tick();
    checks++;
    if (bif.wr_ready_out !== 5'b00010) $display("FAIL route_e_port: wr=%b required 00010", bif.wr_ready_out);
    else passed++;
    checks++;
    if (bif.data_o !== place(f, 1)) $display("FAIL route_e_data: data_o=%h required %h", bif.data_o, place(f, 1));
    else passed++;
    tick();
    checks++;
    if (bif.wr_ready_out !== 5'b00010) $display("FAIL route_e_hold: wr=%b required 00010", bif.wr_ready_out);
    else passed++;
    bif.r_ready_in = 5'b00010;
    tick();
    bif.r_ready_in = '0;
    checks++;
    if (bif.wr_ready_out !== '0) $display("FAIL route_e_drop: wr=%b required 0", bif.wr_ready_out);
    else passed++;
    tick();
    checks++;
    if (rdreq_cnt != 1) $display("FAIL route_e_rdreq: %0d pulses required 1", rdreq_cnt);
    else passed++;
  endtask

  task automatic test_multi_flit();
    do_reset();
    rdreq_cnt = 0;
    push_pkt(4'h0, 3, 1'b1);
    // body flits carry 0xF, which would route elsewhere if recomputed
    exp_flit[1][3:0] = 4'hF;
    exp_flit[2][3:0] = 4'hF;
    fifo[1][3:0] = 4'hF;
    fifo[2][3:0] = 4'hF;
    run_traffic(50, 0, 1'b0);
    checks++;
    if (rdreq_cnt != 3) $display("FAIL multi_rdreq: %0d pulses required 3", rdreq_cnt);
    else passed++;
  endtask

  task automatic test_backpressure_local();
    logic [BUS-1:0] f;
    do_reset();
    f = mk_flit(4'h5, 1'b1);
    fifo.push_back(f);
    upd_empty();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bif.wr_ready_out !== 5'b10000 || bif.data_o !== place(f, 4) || bif.rd_req !== 1'b0)
        $display("FAIL local_hold: cyc=%0d wr=%b rd_req=%b data_o=%h required wr=10000 rd_req=0 data_o=%h",
                 i, bif.wr_ready_out, bif.rd_req, bif.data_o, place(f, 4));
      else passed++;
      tick();
    end
    bif.r_ready_in = 5'b10000;
    tick();
    bif.r_ready_in = '0;
    checks++;
    if (bif.wr_ready_out !== '0) $display("FAIL local_release: wr=%b required 0", bif.wr_ready_out);
    else passed++;
  endtask

  task automatic test_underrun();
    logic [BUS-1:0] h, b;
    do_reset();
    rdreq_cnt = 0;
    h = mk_flit(4'b1001, 1'b0);
    b = mk_flit(4'b0000, 1'b1);
    fifo.push_back(h);
    fifo.push_back(b);
    upd_empty();
    tick();
    tick();
    checks++;
    if (bif.wr_ready_out !== 5'b00100) $display("FAIL underrun_head: wr=%b required 00100", bif.wr_ready_out);
    else passed++;
    bif.r_ready_in = 5'b00100;
    force_empty = 1'b1;
    upd_empty();
    tick();
    bif.r_ready_in = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bif.rd_req !== 1'b0 || bif.wr_ready_out !== '0)
        $display("FAIL underrun_wait: cyc=%0d rd_req=%b wr=%b required 0", i, bif.rd_req, bif.wr_ready_out);
      else passed++;
      tick();
    end
    force_empty = 1'b0;
    upd_empty();
    exp_flit.push_back(b);
    exp_port.push_back(2);
    run_traffic(30, 1, 1'b0);
    checks++;
    if (rdreq_cnt != 2) $display("FAIL underrun_rdreq: %0d pulses required 2", rdreq_cnt);
    else passed++;
  endtask

  task automatic test_spurious_reset();
    do_reset();
    push_pkt(4'b0110, 2, 1'b0);
    tick();
    tick();
    bif.r_ready_in = 5'b11101;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bif.wr_ready_out !== 5'b00010) $display("FAIL spurious_ignored: cyc=%0d wr=%b required 00010", i, bif.wr_ready_out);
      else passed++;
      tick();
    end
    a_rst = 1'b1;
    #1;
    checks++;
    if ({bif.rd_req, bif.wr_ready_out, bif.stall_err} !== '0 || bif.data_o !== '0)
      $display("FAIL reset_in_send: rd_req=%b wr=%b stall=%b data_o=%h required all 0",
               bif.rd_req, bif.wr_ready_out, bif.stall_err, bif.data_o);
    else passed++;
    do_reset();
    // first flit after reset must be treated as a fresh head
    push_pkt(4'h5, 1, 1'b1);
    run_traffic(30, 1, 1'b0);
  endtask

  task automatic test_random();
    int total;
    do_reset();
    rdreq_cnt = 0;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      int len;
      len = $urandom_range(1, 4);
      total += len;
      push_pkt(4'($urandom), len, 1'b1);
    end
    run_traffic(3000, 3, 1'b1);
    checks++;
    if (rdreq_cnt != total) $display("FAIL random_rdreq: %0d pulses required %0d", rdreq_cnt, total);
    else passed++;
  endtask

  task automatic test_watchdog();
    do_reset();
    push_pkt(4'b0110, 1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bif.stall_err !== 1'b0) $display("FAIL wd_early: cyc=%0d stall_err=%b required 0", i, bif.stall_err);
      else passed++;
      tick();
    end
    checks++;
    if (bif.stall_err !== WD_EN) $display("FAIL wd_trip: stall_err=%b required %b", bif.stall_err, WD_EN);
    else passed++;
    bif.r_ready_in = 5'b00010;
    tick();
    bif.r_ready_in = '0;
    repeat (3) tick();
    checks++;
    if (bif.stall_err !== WD_EN) $display("FAIL wd_sticky: stall_err=%b required %b", bif.stall_err, WD_EN);
    else passed++;
  endtask

  initial begin
    a_rst = 1'b1;
    bif.r_ready_in = '0;
    bif.data_i = '0;
    bif.is_empty = 1'b1;
    @(negedge clk);
    test_reset();
    test_route_e();
    test_multi_flit();
    test_backpressure_local();
    test_underrun();
    test_spurious_reset();
    test_random();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d passed so far", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
